// File: rtl/arb_mux_pipe_pkg.sv
// Shared constants and width helpers for the arb_mux_pipe selector.
// Imported by the top level and by the round-robin picker.
package arb_mux_pipe_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Index width for CHANNELS channels; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_pipe_rr_pick.sv
// Round-robin picker: the first set request at or above ptr, wrapping modulo CHANNELS.
// Purely combinational: rotate, priority-encode, then unrotate.
module rr_pick
    import arb_mux_pipe_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [SELW-1:0]     gnt_idx,
    output logic                gnt_any
);

    logic [2*CHANNELS-1:0] rot2;
    logic [CHANNELS-1:0]   rot;
    logic [SELW:0]         sum;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        rot2    = {req, req} >> ptr;
        rot     = rot2[CHANNELS-1:0];
        // Descending scan so the lowest rotated position, i.e. nearest to ptr, wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (SELW+1)'(i);
                if (sum >= (SELW+1)'(CHANNELS)) sum = sum - (SELW+1)'(CHANNELS);
                gnt_idx = sum[SELW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_pipe.sv
// N-channel W-bit selector with one registered output stage and valid/ready handshakes.
// Data is chosen by external select (MODE_SEL) or by round-robin arbitration (MODE_RR).
module arb_mux_pipe
    import arb_mux_pipe_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_SEL,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0]     out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SELW-1:0]     ptr_q, ptr_d;

    logic [SELW-1:0]     rr_idx;
    logic                rr_any;
    logic                can_load;
    logic                sel_ok;
    logic [SELW-1:0]     grant_idx;
    logic                grant_any;
    logic [CHANNELS-1:0] ready_w;
    logic [WIDTH-1:0]    pick_data;
    logic                xfer;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        can_load = !out_valid_q || out_ready;
        sel_ok   = ({1'b0, sel} < (SELW+1)'(CHANNELS));
        if (MODE == MODE_RR) begin
            grant_idx = rr_idx;
            grant_any = can_load && rr_any;
        end else begin
            grant_idx = sel;
            grant_any = can_load && sel_ok;
        end
    end

    // Ready is gated by rst so no channel sees a handshake while the stage is being cleared.
    always_comb begin
        ready_w   = '0;
        pick_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ready_w[k] = !rst && grant_any && (grant_idx == SELW'(k));
            if (ready_w[k]) pick_data = in_data[k*WIDTH +: WIDTH];
        end
        xfer = |(in_valid & ready_w);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = pick_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (MODE == MODE_RR) begin
                if ({1'b0, grant_idx} == (SELW+1)'(CHANNELS - 1)) ptr_d = '0;
                else                                              ptr_d = grant_idx + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign in_ready  = ready_w;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
